mult_cell_pipe: RTL
===================

Name: mult_cell_pipe

Overview:
- Parametrised successor to the CPU multiply cell.
- Does a full WIDTH×WIDTH multiply built from four HALF×HALF unsigned partial products, with signed correction. Result is the low or high word, selected by op mode (MUL/MULH/MULHSU/MULHU).
- Sits in the CPU execute→memory pipeline.
- Adds valid tracking, a global stall enable and an optional output register.

Parameters:
- WIDTH, 32, operand and result width; must be even and ≥4; HALF = WIDTH/2.
- OUT_REG, 1, 1 adds an output register stage (latency 3), 0 gives latency 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; 0 = stall, every register holds.
- in_valid  in  1  operands/op valid this cycle.
- in_op  in  2  mult_op_t: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_src1  in  WIDTH  multiplicand (rs1).
- in_src2  in  WIDTH  multiplier (rs2).
- out_valid  out  1  result valid.
- out_result  out  WIDTH  selected result word.
- out_op  out  2  op that produced out_result (for writeback muxing).

Behaviour:
- Stage 1 (capture), when en=1:
  - Register the four unsigned partial products: pp_ll=a_lo*b_lo, pp_lh=a_lo*b_hi, pp_hl=a_hi*b_lo, pp_hh=a_hi*b_hi, each 2·HALF = WIDTH bits.
  - Register the correction flags: neg_a = src1[WIDTH-1] & (op∈{MULH,MULHSU}); neg_b = src2[WIDTH-1] & (op==MULH).
  - Register src1, src2 (for correction), op and valid (v1 ← in_valid).
- Stage 2 (sum), when en=1:
  - Unsigned product U = pp_ll + (pp_lh<<HALF) + (pp_hl<<HALF) + (pp_hh<<WIDTH), computed in 2·WIDTH bits, modulo 2^(2·WIDTH).
  - Signed product P = U − (neg_a ? src2<<WIDTH : 0) − (neg_b ? src1<<WIDTH : 0), modulo 2^(2·WIDTH).
  - Select result = P[WIDTH-1:0] if op==MUL, else P[2·WIDTH-1:WIDTH]. The low word is independent of signedness.
  - Register result, op and valid (v2 ← v1).
- Output:
  - OUT_REG=1: stage 3 registers result, op and valid when en=1; out_* are driven from stage 3. Latency 3.
  - OUT_REG=0: out_* are driven from stage 2. Latency 2.
- Latency is counted in enabled cycles; cycles with en=0 do not advance.
- Stall (en=0): all data and valid registers hold. out_valid stays asserted on the same result for the whole stall. in_valid is ignored.
- Bubbles: in_valid=0 with en=1 propagates v=0. Data registers still load, but their contents are don't-care when v=0.
- Back-to-back: one new operation accepted per enabled cycle; full throughput, no internal backpressure.
- Reset: on a clk edge with reset=1, every valid bit and out_result/out_op/out_valid clear to 0, and all in-flight operations are discarded. Reset has priority over en. Partial-product registers also clear to 0.
- Reset and in_valid in the same cycle: the input is dropped.
- No overflow flags. Wrap-around is defined modulo 2^(2·WIDTH) as above.

Decomposition:
- Package mult_cell_pkg:
  - typedef mult_op_t (2-bit enum MUL/MULH/MULHSU/MULHU).
  - Function op_is_high(op).
  - Constants for the op encodings.
- Sub-module mult_cell_pp:
  - One registered HALF×HALF unsigned multiplier with en and sync reset.
  - Instantiated four times in stage 1, so it maps to one DSP block each.

Test Plan:
- WIDTH=32, OUT_REG=1, in_src1=in_src2=0xFFFFFFFF, four consecutive cycles with ops MUL, MULHU, MULH, MULHSU.
  - Out_valid pulses on cycles 3–6 with results 0x00000001, 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF, in that order.
- MULH 0x80000000×0x80000000 → 0x40000000; MULH 0x80000000×0x00000001 → 0xFFFFFFFF; MUL 0x00012345×0x00010000 → 0x23450000.
- Stall: issue MUL 7×6, drop en to 0 for 5 cycles after the first stage.
  - out_valid rises exactly 3 enabled cycles after issue, with 42.
  - During a stall with out_valid=1, out_result holds 42 and out_valid stays 1.
- Reset mid-operation: issue 3 back-to-back MULs, assert reset for 1 cycle on the cycle after the third issue.
  - out_valid=0 and out_result=0 from the next edge.
  - No stale result emerges in the following 4 cycles.
- Bubbles: in_valid pattern 1,0,1,0 with en=1 → out_valid pattern 1,0,1,0 starting at latency 3. Repeat with OUT_REG=0 → same pattern starting at latency 2.
- Parameter sweep: WIDTH=8 random 1000 ops of each mode against a reference model P = sext/zext(a)·sext/zext(b); all results match.

Source files
------------

// File: rtl/mult_cell_pkg.sv
// Shared definitions for the pipelined multiply cell.
// Holds the operation encoding, its named constants and small decode helpers.
// These helpers are used by both stage 1 (sign flags) and stage 2 (word select).
package mult_cell_pkg;

    localparam logic [1:0] OP_ENC_MUL    = 2'b00;
    localparam logic [1:0] OP_ENC_MULH   = 2'b01;
    localparam logic [1:0] OP_ENC_MULHSU = 2'b10;
    localparam logic [1:0] OP_ENC_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        OP_MUL    = OP_ENC_MUL,
        OP_MULH   = OP_ENC_MULH,
        OP_MULHSU = OP_ENC_MULHSU,
        OP_MULHU  = OP_ENC_MULHU
    } mult_op_t;

    // Every op except MUL returns the upper word of the double-width product.
    function automatic logic op_is_high(input mult_op_t op);
        return (op != OP_MUL);
    endfunction

    // The multiplicand is signed for MULH and MULHSU.
    function automatic logic op_signed_a(input mult_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // The multiplier is signed only for MULH.
    function automatic logic op_signed_b(input mult_op_t op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mult_cell_pipe_if.sv
// Operand/result bus for mult_cell_pipe.
// The master (the execute stage) drives in_valid, in_op, in_src1 and in_src2.
// The slave (the multiply cell) drives out_valid, out_result and out_op.
// Handshake contract: there is no ready signal. An operation is accepted on
// every rising clk edge where the cell's en is 1 and in_valid is 1. A result
// is present whenever out_valid is 1, and it holds while en is 0.
interface mult_cell_pipe_if #(
    parameter int WIDTH = 32
) ();
    import mult_cell_pkg::*;

    logic             in_valid;
    mult_op_t         in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    mult_op_t         out_op;

    modport master (
        output in_valid, in_op, in_src1, in_src2,
        input  out_valid, out_result, out_op
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2,
        output out_valid, out_result, out_op
    );

endinterface

// File: rtl/mult_cell_pp.sv
// One registered HALF x HALF unsigned multiplier. It is sized to map onto a
// single DSP block.
// Ports: clk, reset (sync, active-high), en (load enable), a_i/b_i (HALF-bit
//        operands), p_o (2*HALF-bit registered product).
module mult_cell_pp #(
    parameter int HALF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [HALF-1:0]   a_i,
    input  logic [HALF-1:0]   b_i,
    output logic [2*HALF-1:0] p_o
);

    logic [2*HALF-1:0] p_q;
    logic [2*HALF-1:0] p_d;

    assign p_d = {{HALF{1'b0}}, a_i} * {{HALF{1'b0}}, b_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
        end else if (en) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mult_cell_pipe.sv
// Pipelined WIDTH x WIDTH multiply cell for the execute->memory path.
// The stages are:
//   stage 1: four HALF x HALF partial products, plus sign-correction flags
//            and the raw operands;
//   stage 2: recombine the partial products, apply the signed correction and
//            select the low or high word;
//   stage 3: optional output register (OUT_REG=1).
// Latency is 3 enabled cycles with OUT_REG=1 and 2 enabled cycles with
// OUT_REG=0. While en is 0, every register holds its value.
// Ports: clk, reset (sync, active-high, has priority over en), en (advance),
//        bus (mult_cell_pipe_if slave: in_valid/in_op/in_src1/in_src2 in,
//        out_valid/out_result/out_op out).
// WIDTH must be even and at least 4.
module mult_cell_pipe
    import mult_cell_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OUT_REG = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    mult_cell_pipe_if.slave bus
);

    localparam int HALF = WIDTH / 2;
    localparam int DW   = 2 * WIDTH;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    mult_cell_pp #(.HALF(HALF)) u_pp_ll (
        .clk(clk), .reset(reset), .en(en),
        .a_i(bus.in_src1[HALF-1:0]), .b_i(bus.in_src2[HALF-1:0]), .p_o(pp_ll)
    );
    mult_cell_pp #(.HALF(HALF)) u_pp_lh (
        .clk(clk), .reset(reset), .en(en),
        .a_i(bus.in_src1[HALF-1:0]), .b_i(bus.in_src2[WIDTH-1:HALF]), .p_o(pp_lh)
    );
    mult_cell_pp #(.HALF(HALF)) u_pp_hl (
        .clk(clk), .reset(reset), .en(en),
        .a_i(bus.in_src1[WIDTH-1:HALF]), .b_i(bus.in_src2[HALF-1:0]), .p_o(pp_hl)
    );
    mult_cell_pp #(.HALF(HALF)) u_pp_hh (
        .clk(clk), .reset(reset), .en(en),
        .a_i(bus.in_src1[WIDTH-1:HALF]), .b_i(bus.in_src2[WIDTH-1:HALF]), .p_o(pp_hh)
    );

    logic             v1_q;
    mult_op_t         op1_q;
    logic [WIDTH-1:0] src1_q, src2_q;
    logic             neg_a_q, neg_b_q;
    logic             neg_a_d, neg_b_d;

    assign neg_a_d = bus.in_src1[WIDTH-1] & op_signed_a(bus.in_op);
    assign neg_b_d = bus.in_src2[WIDTH-1] & op_signed_b(bus.in_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            op1_q   <= OP_MUL;
            src1_q  <= '0;
            src2_q  <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (en) begin
            v1_q    <= bus.in_valid;
            op1_q   <= bus.in_op;
            src1_q  <= bus.in_src1;
            src2_q  <= bus.in_src2;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic [DW-1:0]    u_sum;
    logic [DW-1:0]    corr_a, corr_b;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] result2_d;

    // Two's-complement correction: a signed operand x equals
    // x_unsigned - 2^WIDTH * sign(x). So the unsigned product over-counts by
    // 2^WIDTH times the other operand for each negative signed input.
    always_comb begin
        u_sum = '0;
        corr_a = '0;
        corr_b = '0;
        u_sum = {{WIDTH{1'b0}}, pp_ll}
              + {{HALF{1'b0}}, pp_lh, {HALF{1'b0}}}
              + {{HALF{1'b0}}, pp_hl, {HALF{1'b0}}}
              + {pp_hh, {WIDTH{1'b0}}};
        if (neg_a_q) corr_a = {src2_q, {WIDTH{1'b0}}};
        if (neg_b_q) corr_b = {src1_q, {WIDTH{1'b0}}};
        prod = u_sum - corr_a - corr_b;
        result2_d = op_is_high(op1_q) ? prod[DW-1:WIDTH] : prod[WIDTH-1:0];
    end

    logic             v2_q;
    mult_op_t         op2_q;
    logic [WIDTH-1:0] result2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q      <= 1'b0;
            op2_q     <= OP_MUL;
            result2_q <= '0;
        end else if (en) begin
            v2_q      <= v1_q;
            op2_q     <= op1_q;
            result2_q <= result2_d;
        end
    end

    // ---------------- stage 3 / output ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             v3_q;
            mult_op_t         op3_q;
            logic [WIDTH-1:0] result3_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v3_q      <= 1'b0;
                    op3_q     <= OP_MUL;
                    result3_q <= '0;
                end else if (en) begin
                    v3_q      <= v2_q;
                    op3_q     <= op2_q;
                    result3_q <= result2_q;
                end
            end

            assign bus.out_valid  = v3_q;
            assign bus.out_op     = op3_q;
            assign bus.out_result = result3_q;
        end else begin : g_no_out_reg
            assign bus.out_valid  = v2_q;
            assign bus.out_op     = op2_q;
            assign bus.out_result = result2_q;
        end
    endgenerate

endmodule
